// File: rtl/gba_irq_pkg.sv
// gba_irq_pkg: interrupt source indices, register addresses and HALT state encoding for gba_irq_ctrl
package gba_irq_pkg;
  typedef enum logic [3:0] {
    IRQ_VBLANK, IRQ_HBLANK, IRQ_VCOUNT, IRQ_TIMER0, IRQ_TIMER1, IRQ_TIMER2, IRQ_TIMER3,
    IRQ_SERIAL, IRQ_DMA0, IRQ_DMA1, IRQ_DMA2, IRQ_DMA3, IRQ_KEYPAD, IRQ_GAMEPAK
  } irq_src_e;
  localparam logic [1:0] IRQ_ADDR_IE = 2'd0;
  localparam logic [1:0] IRQ_ADDR_IF = 2'd1;
  localparam logic [1:0] IRQ_ADDR_IME = 2'd2;
  typedef logic halt_state_t;
  localparam halt_state_t HALT_RUN = 1'b0;
  localparam halt_state_t HALT_HALT = 1'b1;
endpackage

// File: rtl/gba_irq_edge.sv
// gba_irq_edge: registered rising-edge detector (clk, rst_n async low, d in, rise out); history resets to ones so sources already high at release do not fire
module gba_irq_edge #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '1;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/gba_irq_ctrl.sv
// gba_irq_ctrl: IE/IF/IME interrupt controller with HALT state (clock_16, async-low reset, irq_src edges, byte-enabled register writes, combinational reads, registered irq_n, cpu_halted)
module gba_irq_ctrl
  import gba_irq_pkg::*;
#(
  parameter int NUM_SRC = 14
) (
  input  logic               clock_16,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [15:0]        wr_data,
  input  logic [1:0]         wr_be,
  input  logic [1:0]         rd_addr,
  output logic [15:0]        rd_data,
  input  logic               halt_req,
  output logic               irq_n,
  output logic               cpu_halted
);
  localparam logic [15:0] SRC_MASK = 16'((17'd1 << NUM_SRC) - 17'd1);
  logic [NUM_SRC-1:0] rise;
  logic [15:0] ie_q, if_q, be_mask, wr_masked;
  logic ime_q, pending, wr_ie, wr_if, wr_ime;
  halt_state_t state;
  gba_irq_edge #(.W(NUM_SRC)) u_edge (
    .clk(clock_16),
    .rst_n(reset),
    .d(irq_src),
    .rise(rise)
  );
  assign be_mask = {{8{wr_be[1]}}, {8{wr_be[0]}}};
  assign wr_masked = wr_data & be_mask;
  assign wr_ie = wr_en && wr_addr == IRQ_ADDR_IE;
  assign wr_if = wr_en && wr_addr == IRQ_ADDR_IF;
  assign wr_ime = wr_en && wr_addr == IRQ_ADDR_IME && wr_be[0];
  assign pending = |(ie_q & if_q);
  assign cpu_halted = state == HALT_HALT;
  always_ff @(posedge clock_16 or negedge reset)
    if (!reset) begin
      ie_q <= '0;
      if_q <= '0;
      ime_q <= 1'b0;
      irq_n <= 1'b1;
      state <= HALT_RUN;
    end else begin
      if (wr_ie) ie_q <= ((ie_q & ~be_mask) | wr_masked) & SRC_MASK;
      if_q <= ((if_q & ~(wr_if ? wr_masked : 16'h0)) | 16'(rise)) & SRC_MASK;
      if (wr_ime) ime_q <= wr_data[0];
      irq_n <= ~(pending & ime_q);
      state <= state == HALT_RUN ? ((halt_req && !pending) ? HALT_HALT : HALT_RUN)
                                 : (pending ? HALT_RUN : HALT_HALT);
    end
  always_comb
    rd_data = rd_addr == IRQ_ADDR_IE  ? ie_q :
              rd_addr == IRQ_ADDR_IF  ? if_q :
              rd_addr == IRQ_ADDR_IME ? {15'd0, ime_q} : 16'h0;
endmodule

// File: tb/tb_gba_irq_ctrl.sv
// tb_gba_irq_ctrl: directed and randomized checks of gba_irq_ctrl against a register-level reference model
module tb_gba_irq_ctrl;
  logic clock_16 = 1'b0;
  logic reset = 1'b0;
  logic [13:0] irq_src = 14'h0008;
  logic wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [15:0] wr_data = 16'h0;
  logic [1:0] wr_be = 2'b11;
  logic [1:0] rd_addr = 2'd0;
  logic [15:0] rd_data;
  logic halt_req = 1'b0;
  logic irq_n, cpu_halted;
  int total = 0, bad = 0;
  logic [15:0] m_ie, m_if;
  logic [13:0] m_prev;
  logic m_ime, m_irq_n, m_halt;
  gba_irq_ctrl dut (
    .clock_16(clock_16), .reset(reset), .irq_src(irq_src), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data), .halt_req(halt_req),
    .irq_n(irq_n), .cpu_halted(cpu_halted)
  );
  always #5 clock_16 = ~clock_16;
  task automatic model_reset();
    m_ie = 16'h0; m_if = 16'h0; m_ime = 1'b0; m_prev = '1; m_irq_n = 1'b1; m_halt = 1'b0;
  endtask
  task automatic step();
    logic [15:0] bm, data, n_ie, n_if;
    logic n_ime, n_irq_n, n_halt, pend;
    bm = {{8{wr_be[1]}}, {8{wr_be[0]}}};
    data = wr_data & bm;
    pend = (m_ie & m_if) != 0;
    n_ie = (wr_en && wr_addr == 0) ? (((m_ie & ~bm) | data) & 16'h3FFF) : m_ie;
    n_if = (wr_en && wr_addr == 1) ? (m_if & ~data) : m_if;
    n_if = n_if | {2'b00, irq_src & ~m_prev};
    n_ime = (wr_en && wr_addr == 2 && wr_be[0]) ? wr_data[0] : m_ime;
    n_irq_n = !(pend && m_ime);
    n_halt = m_halt ? !pend : (halt_req && !pend);
    @(posedge clock_16);
    #1;
    m_ie = n_ie; m_if = n_if; m_ime = n_ime; m_irq_n = n_irq_n; m_halt = n_halt; m_prev = irq_src;
    wr_en = 1'b0; halt_req = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
  endtask
  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask
  task automatic pulse(input logic [13:0] s);
    irq_src = s;
    step();
    irq_src = 14'h0;
  endtask
  task automatic test_reset();
    logic [15:0] v;
    model_reset();
    #12 reset = 1'b1;
    repeat (3) step();
    rd(1, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL reset_if got=%h exp=0000", v); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", cpu_halted); end
    irq_src = 14'h0;
    step();
  endtask
  task automatic test_latency();
    logic [15:0] v;
    wr(0, 16'h0008, 2'b11);
    wr(2, 16'h0001, 2'b11);
    step();
    pulse(14'h0008);
    rd(1, v);
    total++; if (v !== 16'h0008) begin bad++; $display("FAIL lat_if got=%h exp=0008", v); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL lat_irq_early got=%b exp=1", irq_n); end
    step();
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL lat_irq got=%b exp=0", irq_n); end
    wr(1, 16'h0008, 2'b11);
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL clr_irq_early got=%b exp=0", irq_n); end
    step();
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL clr_irq got=%b exp=1", irq_n); end
  endtask
  task automatic test_set_wins();
    logic [15:0] v;
    pulse(14'h0010);
    step();
    irq_src = 14'h0010;
    wr(1, 16'h0010, 2'b11);
    irq_src = 14'h0;
    rd(1, v);
    total++; if (v !== 16'h0010) begin bad++; $display("FAIL set_wins got=%h exp=0010", v); end
  endtask
  task automatic test_ime_gate();
    logic [15:0] v;
    wr(2, 16'h0000, 2'b11);
    wr(0, 16'h0078, 2'b11);
    wr(1, 16'h3FFF, 2'b11);
    pulse(14'h0078);
    repeat (2) step();
    rd(1, v);
    total++; if (v !== 16'h0078) begin bad++; $display("FAIL gate_if got=%h exp=0078", v); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL gate_irq_masked got=%b exp=1", irq_n); end
    wr(2, 16'h0001, 2'b01);
    step();
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL gate_irq_on got=%b exp=0", irq_n); end
  endtask
  task automatic test_halt();
    wr(2, 16'h0000, 2'b11);
    wr(0, 16'h0001, 2'b11);
    wr(1, 16'h3FFF, 2'b11);
    step();
    halt_req = 1'b1;
    step();
    total++; if (cpu_halted !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b exp=1", cpu_halted); end
    repeat (3) step();
    pulse(14'h0001);
    total++; if (cpu_halted !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b exp=1", cpu_halted); end
    step();
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL halt_wake got=%b exp=0", cpu_halted); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL halt_irq got=%b exp=1", irq_n); end
    halt_req = 1'b1;
    step();
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL halt_refused got=%b exp=0", cpu_halted); end
  endtask
  task automatic test_be_reset();
    logic [15:0] v;
    wr(0, 16'h0000, 2'b11);
    wr(0, 16'hFFFF, 2'b10);
    rd(0, v);
    total++; if (v !== 16'h3F00) begin bad++; $display("FAIL be_ie got=%h exp=3F00", v); end
    wr(2, 16'hFF01, 2'b10);
    rd(2, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL be_ime got=%h exp=0000", v); end
    wr(3, 16'hFFFF, 2'b11);
    rd(3, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL rsv_rd got=%h exp=0000", v); end
    wr(1, 16'h3FFF, 2'b11);
    wr(2, 16'h0001, 2'b11);
    halt_req = 1'b1;
    step();
    total++; if (cpu_halted !== 1'b1) begin bad++; $display("FAIL pre_rst_halt got=%b exp=1", cpu_halted); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", cpu_halted); end
    rd(0, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL rst_ie got=%h exp=0000", v); end
    rd(2, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL rst_ime got=%h exp=0000", v); end
    @(negedge clock_16);
    reset = 1'b1;
    step();
  endtask
  task automatic test_random();
    logic [15:0] v, exp;
    for (int i = 0; i < 400; i++) begin
      irq_src = 14'($urandom) & 14'($urandom);
      wr_en = $urandom_range(0, 2) == 0;
      wr_addr = 2'($urandom);
      wr_data = 16'($urandom);
      wr_be = 2'($urandom);
      halt_req = $urandom_range(0, 5) == 0;
      step();
      total++; if (irq_n !== m_irq_n) begin bad++; $display("FAIL rnd_irq_n cyc=%0d got=%b exp=%b", i, irq_n, m_irq_n); end
      total++; if (cpu_halted !== m_halt) begin bad++; $display("FAIL rnd_halt cyc=%0d got=%b exp=%b", i, cpu_halted, m_halt); end
      rd(2'(i), v);
      exp = i % 4 == 0 ? m_ie : i % 4 == 1 ? m_if : i % 4 == 2 ? {15'd0, m_ime} : 16'h0;
      total++; if (v !== exp) begin bad++; $display("FAIL rnd_rd cyc=%0d addr=%0d got=%h exp=%h", i, i % 4, v, exp); end
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_set_wins();
    test_ime_gate();
    test_halt();
    test_be_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
